// File: rtl/combo_pkg.sv
// -----------------------------------------------------------------------------
// combo_pkg
// Shared definitions for the pattern-mode controller: the controller state
// encoding, the number of pattern-select lines and the default debounce length.
// -----------------------------------------------------------------------------
package combo_pkg;

   // Number of one-hot pattern-select lines (slide switches / sw_1..sw_4).
   localparam int MODE_W = 4;

   // Default debounce length in clock cycles. Kept short so simulation stays
   // quick; builds for hardware override it (around 1_000_000 at 50 MHz).
   localparam int DEB_CYCLES_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAUSE   = 2'd1,
      ST_RUN     = 2'd2,
      ST_RESTART = 2'd3
   } state_t;

endpackage

// File: rtl/debounce.sv
// -----------------------------------------------------------------------------
// debounce
// Two-flop synchronizer followed by a consecutive-mismatch counter.
// The output follows the synchronized input only after the synchronized value
// has disagreed with the output on every cycle of a full debounce window; any
// agreeing cycle restarts the count. Latency from the edge that first samples a
// change to the output changing is 2 + DEB_CYCLES cycles.
//
// Ports
//   clk   in  1  clock (rising edge)
//   srst  in  1  synchronous active-high reset, clears every flop
//   din   in  1  raw asynchronous input
//   dout  out 1  debounced level (registered)
// -----------------------------------------------------------------------------
module debounce
   import combo_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int DEB_W      = 20
) (
   input  logic clk,
   input  logic srst,
   input  logic din,
   output logic dout
);

   logic             sync1_reg;
   logic             sync2_reg;
   logic             deb_reg;
   logic [DEB_W-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         deb_reg   <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         sync1_reg <= din;
         sync2_reg <= sync1_reg;
         if (sync2_reg != deb_reg) begin
            // The counter has already recorded DEB_CYCLES mismatching cycles;
            // this further mismatch commits the new level.
            if (cnt_reg == DEB_W'(DEB_CYCLES)) begin
               deb_reg <= sync2_reg;
               cnt_reg <= '0;
            end else begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end else begin
            cnt_reg <= '0;
         end
      end
   end

   assign dout = deb_reg;

endmodule

// File: rtl/mode_ctrl.sv
// -----------------------------------------------------------------------------
// mode_ctrl
// Front-end controller for the Combo_str pattern stage. Debounces four slide
// switches (one-hot pattern select) and a run/pause pushbutton, keeps the
// selected mode, and sequences IDLE / PAUSE / RUN / RESTART. Every mode change
// produces a one-cycle rst_pat pulse together with the new select lines.
//
// Ports
//   clk_50   in  1  50 MHz system clock (rising edge)
//   rst      in  1  synchronous active-high reset
//   sw_raw   in  4  raw slide switches, bit0 = pattern 1 .. bit3 = pattern 4
//   btn_raw  in  1  raw run/pause pushbutton, active-high
//   sw_1..4  out 1  registered one-hot pattern select
//   en       out 1  registered pattern-run enable
//   rst_pat  out 1  registered one-cycle pattern restart pulse
// -----------------------------------------------------------------------------
module mode_ctrl
   import combo_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int DEB_W      = 20
) (
   input  logic              clk_50,
   input  logic              rst,
   input  logic [MODE_W-1:0] sw_raw,
   input  logic              btn_raw,
   output logic              sw_1,
   output logic              sw_2,
   output logic              sw_3,
   output logic              sw_4,
   output logic              en,
   output logic              rst_pat
);

   logic [MODE_W-1:0] sw_deb;
   logic              btn_deb;

   generate
      for (genvar gi = 0; gi < MODE_W; gi++) begin : g_sw_deb
         debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .DEB_W      (DEB_W)
         ) u_sw_deb (
            .clk  (clk_50),
            .srst (rst),
            .din  (sw_raw[gi]),
            .dout (sw_deb[gi])
         );
      end
   endgenerate

   debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .DEB_W      (DEB_W)
   ) u_btn_deb (
      .clk  (clk_50),
      .srst (rst),
      .din  (btn_raw),
      .dout (btn_deb)
   );

   state_t            state_reg;
   logic [MODE_W-1:0] mode_reg;
   logic [MODE_W-1:0] sw_out_reg;
   logic              resume_run_reg;
   logic              btn_prev_reg;
   logic              en_reg;
   logic              rst_pat_reg;

   logic cand_valid;
   logic mode_change;
   logic btn_event;

   // Zero or several switches up means "no selection": the current mode holds.
   assign cand_valid  = $onehot(sw_deb);
   assign mode_change = cand_valid && (sw_deb != mode_reg);
   // Only the press edge of the debounced button is an event.
   assign btn_event   = btn_deb && !btn_prev_reg;

   always_ff @(posedge clk_50) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         mode_reg       <= '0;
         sw_out_reg     <= '0;
         resume_run_reg <= 1'b0;
         btn_prev_reg   <= 1'b0;
         en_reg         <= 1'b0;
         rst_pat_reg    <= 1'b0;
      end else begin
         btn_prev_reg <= btn_deb;
         rst_pat_reg  <= 1'b0;
         if (mode_change) begin
            // A mode change outranks a coincident button event, which is
            // simply dropped. A further change while already restarting
            // issues another pulse but keeps the original resume target.
            mode_reg       <= sw_deb;
            sw_out_reg     <= sw_deb;
            rst_pat_reg    <= 1'b1;
            en_reg         <= 1'b0;
            state_reg      <= ST_RESTART;
            resume_run_reg <= (state_reg == ST_RUN) ||
                              ((state_reg == ST_RESTART) && resume_run_reg);
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  en_reg     <= 1'b0;
                  sw_out_reg <= '0;
               end
               ST_RESTART: begin
                  // Button events seen here are discarded.
                  state_reg <= resume_run_reg ? ST_RUN : ST_PAUSE;
                  en_reg    <= resume_run_reg;
               end
               ST_PAUSE: begin
                  if (btn_event) begin
                     state_reg <= ST_RUN;
                     en_reg    <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (btn_event) begin
                     state_reg <= ST_PAUSE;
                     en_reg    <= 1'b0;
                  end
               end
               default: begin
                  state_reg <= ST_IDLE;
                  en_reg    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign sw_1    = sw_out_reg[0];
   assign sw_2    = sw_out_reg[1];
   assign sw_3    = sw_out_reg[2];
   assign sw_4    = sw_out_reg[3];
   assign en      = en_reg;
   assign rst_pat = rst_pat_reg;

endmodule

// File: tb/tb_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mode_ctrl
// Directed bench for mode_ctrl with DEB_CYCLES = 4: a table of
// {inputs, hold time, expected outputs, expected restart pulses} records plus
// hand-written sequences for exact latencies and reset behaviour.
// -----------------------------------------------------------------------------
module tb_mode_ctrl;

   logic       clk_50  = 1'b0;
   logic       rst     = 1'b1;
   logic [3:0] sw_raw  = 4'b0000;
   logic       btn_raw = 1'b0;
   logic       sw_1, sw_2, sw_3, sw_4, en, rst_pat;
   logic [3:0] sw_bus;

   assign sw_bus = {sw_4, sw_3, sw_2, sw_1};

   mode_ctrl #(
      .DEB_CYCLES (4),
      .DEB_W      (3)
   ) dut (
      .clk_50  (clk_50),
      .rst     (rst),
      .sw_raw  (sw_raw),
      .btn_raw (btn_raw),
      .sw_1    (sw_1),
      .sw_2    (sw_2),
      .sw_3    (sw_3),
      .sw_4    (sw_4),
      .en      (en),
      .rst_pat (rst_pat)
   );

   always #10 clk_50 = ~clk_50;

   typedef struct {
      logic [3:0] sw;
      logic       btn;
      int         cycles;
      logic [3:0] exp_sw;
      logic       exp_en;
      int         exp_pulses;
   } vec_t;

   vec_t vecs[17];

   int n_vec  = 0;
   int n_fail = 0;

   // Observations gathered by watch().
   int pulses;
   int first_pulse;
   int en_at_pulse;
   int en_after;
   int en_chg;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk_50);
      #1;
   endtask

   // Run n cycles. Tick index 0 is the edge that first samples inputs driven
   // just before the call.
   task automatic watch(input int n);
      logic en_prev;
      pulses      = 0;
      first_pulse = -1;
      en_at_pulse = -1;
      en_after    = -1;
      en_chg      = -1;
      en_prev     = en;
      for (int k = 0; k < n; k++) begin
         tick();
         if (first_pulse >= 0 && k == first_pulse + 1) en_after = int'(en);
         if (rst_pat) begin
            pulses++;
            if (first_pulse < 0) begin
               first_pulse = k;
               en_at_pulse = int'(en);
            end
         end
         if (en != en_prev && en_chg < 0) en_chg = k;
         en_prev = en;
      end
   endtask

   initial begin
      // Entry state for the table: PAUSE, mode 1000, button released.
      vecs[0]  = '{4'b1000, 1'b1, 10, 4'b1000, 1'b1, 0}; // press -> RUN
      vecs[1]  = '{4'b1000, 1'b0, 10, 4'b1000, 1'b1, 0}; // release ignored
      vecs[2]  = '{4'b0100, 1'b0,  2, 4'b1000, 1'b1, 0}; // 2-cycle glitch
      vecs[3]  = '{4'b1000, 1'b0, 12, 4'b1000, 1'b1, 0}; // glitch rejected
      vecs[4]  = '{4'b0100, 1'b0, 12, 4'b0100, 1'b1, 1}; // stable change
      vecs[5]  = '{4'b1100, 1'b0, 12, 4'b0100, 1'b1, 0}; // two set: hold
      vecs[6]  = '{4'b0000, 1'b0, 12, 4'b0100, 1'b1, 0}; // none set: hold
      vecs[7]  = '{4'b0001, 1'b0, 12, 4'b0001, 1'b1, 1}; // valid again
      vecs[8]  = '{4'b0001, 1'b1, 10, 4'b0001, 1'b0, 0}; // press -> PAUSE
      vecs[9]  = '{4'b0001, 1'b0, 10, 4'b0001, 1'b0, 0};
      vecs[10] = '{4'b0010, 1'b0, 12, 4'b0010, 1'b0, 1}; // restart -> PAUSE
      vecs[11] = '{4'b0100, 1'b1, 10, 4'b0100, 1'b0, 1}; // coincide in PAUSE
      vecs[12] = '{4'b0100, 1'b0, 10, 4'b0100, 1'b0, 0};
      vecs[13] = '{4'b0100, 1'b1, 10, 4'b0100, 1'b1, 0}; // press -> RUN
      vecs[14] = '{4'b0100, 1'b0, 10, 4'b0100, 1'b1, 0};
      vecs[15] = '{4'b1000, 1'b1, 10, 4'b1000, 1'b1, 1}; // coincide in RUN
      vecs[16] = '{4'b1000, 1'b0, 10, 4'b1000, 1'b1, 0};

      // Reset state.
      rst = 1'b1; sw_raw = 4'b0000; btn_raw = 1'b0;
      repeat (3) tick();
      check("reset_sw", int'(sw_bus), 0);
      check("reset_en", int'(en), 0);
      check("reset_rst_pat", int'(rst_pat), 0);
      rst = 1'b0;
      repeat (3) tick();

      // First selection out of IDLE: pulse 7 cycles after first sample.
      sw_raw = 4'b1000;
      watch(12);
      check("pu_pulse_at", first_pulse, 7);
      check("pu_pulses", pulses, 1);
      check("pu_en_at_pulse", en_at_pulse, 0);
      check("pu_sw", int'(sw_bus), 8);
      check("pu_en", int'(en), 0);

      // Button in PAUSE: en rises 7 cycles after first sample.
      btn_raw = 1'b1;
      watch(10);
      check("btn1_en_rise_at", en_chg, 7);
      btn_raw = 1'b0;
      watch(10);
      check("btn1_release_en", int'(en), 1);
      btn_raw = 1'b1;
      watch(10);
      check("btn2_en_fall_at", en_chg, 7);
      btn_raw = 1'b0;
      watch(10);
      check("btn2_release_en", int'(en), 0);
      check("btn2_pulses", pulses, 0);

      // Table-driven vectors.
      for (int i = 0; i < 17; i++) begin
         sw_raw  = vecs[i].sw;
         btn_raw = vecs[i].btn;
         watch(vecs[i].cycles);
         check($sformatf("v%0d_pulses", i), pulses, vecs[i].exp_pulses);
         check($sformatf("v%0d_sw", i), int'(sw_bus), int'(vecs[i].exp_sw));
         check($sformatf("v%0d_en", i), int'(en), int'(vecs[i].exp_en));
      end

      // Stable change in RUN: en low during the pulse, high one cycle later.
      sw_raw = 4'b0001;
      watch(12);
      check("run_chg_pulse_at", first_pulse, 7);
      check("run_chg_pulses", pulses, 1);
      check("run_chg_en_at_pulse", en_at_pulse, 0);
      check("run_chg_en_after", en_after, 1);
      check("run_chg_sw", int'(sw_bus), 1);

      // Reset in RUN with switch 1000 stable.
      sw_raw = 4'b1000;
      watch(12);
      check("pre_rst_en", int'(en), 1);
      rst = 1'b1;
      tick();
      check("mid_rst_sw", int'(sw_bus), 0);
      check("mid_rst_en", int'(en), 0);
      check("mid_rst_rst_pat", int'(rst_pat), 0);
      rst = 1'b0;
      watch(12);
      check("post_rst_pulse_at", first_pulse, 7);
      check("post_rst_pulses", pulses, 1);
      check("post_rst_sw", int'(sw_bus), 8);
      check("post_rst_en", int'(en), 0);

      // IDLE with invalid switches stays dark.
      rst = 1'b1; sw_raw = 4'b1100;
      tick();
      rst = 1'b0;
      watch(15);
      check("idle_multi_pulses", pulses, 0);
      check("idle_multi_sw", int'(sw_bus), 0);
      check("idle_multi_en", int'(en), 0);
      sw_raw = 4'b0000;
      btn_raw = 1'b1;
      watch(12);
      check("idle_none_pulses", pulses, 0);
      check("idle_none_sw", int'(sw_bus), 0);
      check("idle_btn_en", int'(en), 0);
      btn_raw = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
